// File: rtl/framing_pkg.sv
// Shared types and constants for the byte-parallel PHY framer.
package framing_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_PHR, ST_PAY, ST_FCS, ST_DRAIN
  } state_e;

  localparam logic [15:0] CRC16_X25_POLY = 16'h8408;
  localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
endpackage

// File: rtl/framing_crc_stream_if.sv
// Byte stream with valid/ready handshake plus first/last frame markers.
interface framing_crc_stream_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       first;
  logic       last;

  modport master (output data, valid, first, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/framing_crc_stream_crc_byte_step.sv
// One byte of reflected CRC update, LSB of the data byte first.
module crc_byte_step
  import framing_pkg::*;
#(
  parameter int               CRC_W    = 16,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC16_X25_POLY)
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       byte_i,
  output logic [CRC_W-1:0] crc_o
);
  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++)
      crc_o = (crc_o >> 1) ^ ((crc_o[0] ^ byte_i[i]) ? CRC_POLY : '0);
  end
endmodule

// File: rtl/framing_crc_stream.sv
// Wraps a PHR+PSDU byte stream into preamble, SFD, PHR, payload and inverted FCS.
// Framing length comes from the PHR; s_last is only cross-checked against it.
module framing_crc_stream
  import framing_pkg::*;
#(
  parameter int               PREAMBLE_BYTES = 4,
  parameter logic [7:0]       PREAMBLE_BYTE  = 8'hAA,
  parameter logic [15:0]      SFD            = 16'h98F3,
  parameter int               CRC_W          = 16,
  parameter logic [CRC_W-1:0] CRC_POLY       = CRC_W'(CRC16_X25_POLY),
  parameter logic [CRC_W-1:0] CRC_INIT       = '1,
  parameter int               MAX_LEN        = 127
) (
  input  logic                  clk,
  input  logic                  reset,
  framing_crc_stream_if.slave   s_if,
  framing_crc_stream_if.master  m_if,
  output logic                  busy,
  output logic                  err_len
);
  localparam logic [6:0] NB7      = 7'(CRC_W / 8);
  localparam logic [6:0] PRE_LAST = 7'(PREAMBLE_BYTES - 1);

  state_e           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d, plen_q, plen_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_step, crc_inv, fcs_sh;
  logic             pad_q, pad_d, drain_q, drain_d;
  logic             fire, len_bad;
  logic [6:0]       len;

  assign fire    = m_if.valid & m_if.ready;
  assign len     = s_if.data[6:0];
  assign len_bad = (len < NB7) || ({1'b0, len} > 8'(MAX_LEN));
  assign crc_inv = ~crc_q;
  assign fcs_sh  = crc_inv >> {cnt_q, 3'b000};

  // Pads reach the CRC through m_data, which is forced to zero in pad mode.
  crc_byte_step #(.CRC_W(CRC_W), .CRC_POLY(CRC_POLY)) u_crc (
    .crc_i  (crc_q),
    .byte_i (m_if.data),
    .crc_o  (crc_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      plen_q  <= '0;
      crc_q   <= CRC_INIT;
      pad_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      crc_q   <= crc_d;
      pad_q   <= pad_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    crc_d   = crc_q;
    pad_d   = pad_q;
    drain_d = drain_q;
    err_len = 1'b0;
    case (state_q)
      ST_IDLE: if (s_if.valid) state_d = ST_PRE;
      ST_PRE: if (fire) begin
        if (cnt_q == PRE_LAST) begin cnt_d = '0; state_d = ST_SFD; end
        else cnt_d = cnt_q + 7'd1;
      end
      ST_SFD: if (fire) begin
        if (cnt_q == 7'd1) begin cnt_d = '0; state_d = ST_PHR; end
        else cnt_d = cnt_q + 7'd1;
      end
      ST_PHR: if (fire) begin
        crc_d   = CRC_INIT;
        pad_d   = 1'b0;
        drain_d = 1'b0;
        if (len_bad) begin
          err_len = 1'b1;
          plen_d  = '0;
          state_d = ST_FCS;
        end else begin
          plen_d = len - NB7;
          if (len == NB7) state_d = ST_FCS;
          else begin
            state_d = ST_PAY;
            if (s_if.last) begin err_len = 1'b1; pad_d = 1'b1; end
          end
        end
      end
      ST_PAY: if (fire) begin
        crc_d = crc_step;
        if (cnt_q == plen_q - 7'd1) begin
          cnt_d   = '0;
          state_d = ST_FCS;
          if (!pad_q && !s_if.last) begin err_len = 1'b1; drain_d = 1'b1; end
        end else begin
          cnt_d = cnt_q + 7'd1;
          if (!pad_q && s_if.last) begin err_len = 1'b1; pad_d = 1'b1; end
        end
      end
      ST_FCS: if (fire) begin
        if (cnt_q == NB7 - 7'd1) begin
          cnt_d   = '0;
          state_d = drain_q ? ST_DRAIN : ST_IDLE;
          pad_d   = 1'b0;
          drain_d = 1'b0;
        end else cnt_d = cnt_q + 7'd1;
      end
      ST_DRAIN: if (s_if.valid && s_if.last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_if.data  = '0;
    m_if.valid = 1'b0;
    m_if.first = 1'b0;
    m_if.last  = 1'b0;
    s_if.ready = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_PRE: begin
        m_if.data  = PREAMBLE_BYTE;
        m_if.valid = 1'b1;
        m_if.first = (cnt_q == '0);
      end
      ST_SFD: begin
        m_if.data  = (cnt_q == '0) ? SFD[15:8] : SFD[7:0];
        m_if.valid = 1'b1;
      end
      ST_PHR: begin
        m_if.data  = s_if.data;
        m_if.valid = s_if.valid;
        s_if.ready = m_if.ready;
      end
      ST_PAY: begin
        if (pad_q) m_if.valid = 1'b1;
        else begin
          m_if.data  = s_if.data;
          m_if.valid = s_if.valid;
          s_if.ready = m_if.ready;
        end
      end
      ST_FCS: begin
        m_if.data  = fcs_sh[7:0];
        m_if.valid = 1'b1;
        m_if.last  = (cnt_q == NB7 - 7'd1);
      end
      ST_DRAIN: s_if.ready = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_framing_crc_stream.sv
// Directed bench for framing_crc_stream: CRC16 and CRC32 instances share one source driver.
module tb_framing_crc_stream;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] drv_data = '0;
  logic drv_valid = 1'b0, drv_last = 1'b0, mrdy = 1'b1, sel32 = 1'b0;
  bit   rand_rdy = 1'b0;

  framing_crc_stream_if s16(), m16(), s32(), m32();
  assign s16.data  = drv_data;
  assign s16.valid = drv_valid & ~sel32;
  assign s16.last  = drv_last;
  assign s16.first = 1'b0;
  assign s32.data  = drv_data;
  assign s32.valid = drv_valid & sel32;
  assign s32.last  = drv_last;
  assign s32.first = 1'b0;
  assign m16.ready = mrdy;
  assign m32.ready = mrdy;

  logic busy16, err16, busy32, err32;

  framing_crc_stream #(.CRC_W(16), .CRC_POLY(16'h8408)) u16 (
    .clk(clk), .reset(reset), .s_if(s16), .m_if(m16), .busy(busy16), .err_len(err16));
  framing_crc_stream #(.CRC_W(32), .CRC_POLY(32'hEDB88320)) u32 (
    .clk(clk), .reset(reset), .s_if(s32), .m_if(m32), .busy(busy32), .err_len(err32));

  logic [7:0] md;
  logic mv, mf, ml, sr, bz, er;
  always_comb begin
    if (sel32) begin
      md = m32.data; mv = m32.valid; mf = m32.first; ml = m32.last;
      sr = s32.ready; bz = busy32; er = err32;
    end else begin
      md = m16.data; mv = m16.valid; mf = m16.first; ml = m16.last;
      sr = s16.ready; bz = busy16; er = err16;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output collector and hold-stability monitor
  logic [7:0] out_q[$];
  bit first_q[$], last_q[$];
  int err_cnt = 0;
  bit hold_pend = 1'b0;
  logic [7:0] hold_d = '0;

  always @(negedge clk) begin
    if (reset) hold_pend <= 1'b0;
    else begin
      if (hold_pend) check("hold_stable", {23'd0, mv, md}, {23'd0, 1'b1, hold_d});
      if (er) err_cnt <= err_cnt + 1;
      if (mv && mrdy) begin
        out_q.push_back(md);
        first_q.push_back(mf);
        last_q.push_back(ml);
      end
      hold_pend <= mv && !mrdy;
      hold_d    <= md;
    end
  end

  always @(posedge clk) begin
    #1;
    mrdy <= rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [15:0] crc16_fcs(input bq_t b);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t hdr(input logic [7:0] phr);
    bq_t q = {8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h98, 8'hF3, phr};
    return q;
  endfunction

  task automatic push(input logic [7:0] d, input bit last, input bit gaps);
    int n = 0;
    bit ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    drv_data = d; drv_valid = 1'b1; drv_last = last;
    while (!ok && n < 500) begin
      @(negedge clk); ok = sr;
      @(posedge clk); #1; n++;
    end
    drv_valid = 1'b0; drv_last = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input string tag, input bq_t din, input int last_idx,
                           input bq_t exp, input int exp_err, input bit gaps);
    int e0, n, nf, nl;
    bit done;
    out_q.delete(); first_q.delete(); last_q.delete();
    e0 = err_cnt;
    foreach (din[i]) push(din[i], i == last_idx, gaps);
    n = 0; done = 1'b0;
    while (!done && n < 2000) begin
      done = (last_q.size() > 0) && last_q[$];
      if (!done) begin @(posedge clk); #1; n++; end
    end
    repeat (3) begin @(posedge clk); #1; end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " nbytes"}, out_q.size(), exp.size());
    foreach (exp[i])
      if (i < out_q.size()) check($sformatf("%s byte%0d", tag, i), out_q[i], exp[i]);
    nf = 0; nl = 0;
    foreach (first_q[i]) nf += int'(first_q[i]);
    foreach (last_q[i]) nl += int'(last_q[i]);
    check({tag, " first_cnt"}, nf, 1);
    check({tag, " last_cnt"}, nl, 1);
    if (first_q.size() > 0) check({tag, " first_pos"}, 32'(first_q[0]), 32'd1);
    check({tag, " err_len"}, err_cnt - e0, exp_err);
    @(negedge clk);
    check({tag, " busy_after"}, 32'(bz), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t din, exp, pay, p9;
    logic [15:0] f;
    p9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst m_valid", 32'(mv), 32'd0);
    check("rst m_data",  32'(md), 32'd0);
    check("rst s_ready", 32'(sr), 32'd0);
    check("rst m_first", 32'(mf), 32'd0);
    check("rst m_last",  32'(ml), 32'd0);
    check("rst busy",    32'(bz), 32'd0);
    check("rst err_len", 32'(er), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    din = {8'h0B}; din = {din, p9};
    exp = {hdr(8'h0B), p9, 8'h6E, 8'h90};
    run_frame("crc16", din, 9, exp, 0, 1'b0);

    run_frame("empty", {8'h02}, 0, {hdr(8'h02), 8'h00, 8'h00}, 0, 1'b0);

    rand_rdy = 1'b1;
    run_frame("gaps", din, 9, exp, 0, 1'b1);
    rand_rdy = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00};
    f = crc16_fcs(pay);
    run_frame("early_last", {8'h0B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35}, 5,
              {hdr(8'h0B), pay, f[7:0], f[15:8]}, 1, 1'b0);

    pay = {8'h31, 8'h32, 8'h33};
    f = crc16_fcs(pay);
    run_frame("drain", {8'h05, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35}, 5,
              {hdr(8'h05), pay, f[7:0], f[15:8]}, 1, 1'b0);

    run_frame("after_drain", din, 9, exp, 0, 1'b0);

    // Abort mid-payload, then a clean frame must follow
    push(8'h0B, 1'b0, 1'b0);
    push(8'h31, 1'b0, 1'b0);
    push(8'h32, 1'b0, 1'b0);
    push(8'h33, 1'b0, 1'b0);
    check("pre_abort busy", 32'(bz), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort m_valid", 32'(mv), 32'd0);
    check("abort busy",    32'(bz), 32'd0);
    check("abort s_ready", 32'(sr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_frame("post_abort", din, 9, exp, 0, 1'b0);

    sel32 = 1'b1;
    @(posedge clk); #1;
    din = {8'h0D}; din = {din, p9};
    run_frame("crc32", din, 9, {hdr(8'h0D), p9, 8'h26, 8'h39, 8'hF4, 8'hCB}, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
